// File: rtl/ysyx_24120013_gpr_pkg.sv
// Shared GPR constants for the IDU, EXU and register file.
// Register count helper keeps per-instance widths consistent.
package ysyx_24120013_gpr_pkg;

   localparam int unsigned GPR_ADDR_WIDTH = 5;
   localparam int unsigned GPR_DATA_WIDTH = 32;
   localparam int unsigned NUM_REGS       = 1 << GPR_ADDR_WIDTH;
   localparam int unsigned REG_ZERO       = 0;

   function automatic int unsigned num_regs(input int unsigned addr_width);
      return 1 << addr_width;
   endfunction

endpackage

// File: rtl/ysyx_24120013_gpr_if.sv
// Execute-stage write-back channel into the register file (valid/ready).
interface ysyx_24120013_gpr_if
   import ysyx_24120013_gpr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH
);

   logic                  wb_valid;
   logic                  wb_ready;
   logic                  wb_wen;
   logic [ADDR_WIDTH-1:0] wb_waddr;
   logic [DATA_WIDTH-1:0] wb_wdata;

   modport master (output wb_valid, wb_wen, wb_waddr, wb_wdata, input wb_ready);
   modport slave  (input wb_valid, wb_wen, wb_waddr, wb_wdata, output wb_ready);

endinterface

// File: rtl/ysyx_24120013_scoreboard.sv
// Per-register pending bits: set on issue, cleared on write-back handshake.
// Flags a sticky error when a write-back arrives for a register nobody issued.
module ysyx_24120013_scoreboard
   import ysyx_24120013_gpr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wb_hs,
   input  logic [ADDR_WIDTH-1:0]        wb_waddr,
   input  logic                         iss_valid,
   input  logic [ADDR_WIDTH-1:0]        iss_rd,
   output logic [(1<<ADDR_WIDTH)-1:0]   pending,
   output logic                         wb_err
);

   logic                       iss_set;
   logic                       stray_wb;
   logic [(1<<ADDR_WIDTH)-1:0] pending_next;

   assign iss_set  = iss_valid && (iss_rd != ADDR_WIDTH'(REG_ZERO));
   assign stray_wb = wb_hs && (wb_waddr != ADDR_WIDTH'(REG_ZERO)) && !pending[wb_waddr]
                     && !(iss_set && (iss_rd == wb_waddr));

   // Clear first, then set, so a same-cycle issue to the same index wins.
   always_comb begin
      pending_next = pending;
      if (wb_hs)
         pending_next[wb_waddr] = 1'b0;
      if (iss_set)
         pending_next[iss_rd] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending <= '0;
         wb_err  <= 1'b0;
      end else begin
         pending <= pending_next;
         if (stray_wb)
            wb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/ysyx_24120013_gpr.sv
// NPC general-purpose register file: x0 hardwired to zero, one write per cycle,
// two combinational read ports with write-first bypass and pending status.
module ysyx_24120013_gpr
   import ysyx_24120013_gpr_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = GPR_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = GPR_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   ysyx_24120013_gpr_if.slave    wb,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   input  logic [ADDR_WIDTH-1:0] raddr1,
   input  logic [ADDR_WIDTH-1:0] raddr2,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [DATA_WIDTH-1:0] rdata2,
   output logic                  rvalid1,
   output logic                  rvalid2,
   output logic                  wb_err
);

   localparam int unsigned NREGS = num_regs(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] regs [NREGS];
   logic [NREGS-1:0]      pending;
   logic                  wb_hs;
   logic                  wr_fire;

   assign wb_hs   = wb.wb_valid && wb.wb_ready;
   assign wr_fire = wb_hs && wb.wb_wen && (wb.wb_waddr != ADDR_WIDTH'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (!rst)
         wb.wb_ready <= 1'b0;
      else
         wb.wb_ready <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NREGS; i++)
            regs[i] <= '0;
      end else if (wr_fire) begin
         regs[wb.wb_waddr] <= wb.wb_wdata;
      end
   end

   ysyx_24120013_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .wb_hs     (wb_hs),
      .wb_waddr  (wb.wb_waddr),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .pending   (pending),
      .wb_err    (wb_err)
   );

   always_comb begin
      rdata1  = regs[raddr1];
      rvalid1 = !pending[raddr1];
      if (raddr1 == ADDR_WIDTH'(REG_ZERO)) begin
         rdata1  = '0;
         rvalid1 = 1'b1;
      end else if (wr_fire && (wb.wb_waddr == raddr1)) begin
         rdata1  = wb.wb_wdata;
         rvalid1 = 1'b1;
      end
   end

   always_comb begin
      rdata2  = regs[raddr2];
      rvalid2 = !pending[raddr2];
      if (raddr2 == ADDR_WIDTH'(REG_ZERO)) begin
         rdata2  = '0;
         rvalid2 = 1'b1;
      end else if (wr_fire && (wb.wb_waddr == raddr2)) begin
         rdata2  = wb.wb_wdata;
         rvalid2 = 1'b1;
      end
   end

endmodule

// File: tb/tb_ysyx_24120013_gpr.sv
// Bench for the GPR: directed vector table, then randomized traffic checked
// against an array-based reference model of the register file rules.
module tb_ysyx_24120013_gpr;
   import ysyx_24120013_gpr_pkg::*;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          iss_valid;
   logic [AW-1:0] iss_rd, raddr1, raddr2;
   logic [DW-1:0] rdata1, rdata2;
   logic          rvalid1, rvalid2, wb_err;

   always #5 clk = ~clk;

   ysyx_24120013_gpr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_bus ();

   ysyx_24120013_gpr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .wb        (wb_bus.slave),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .raddr1    (raddr1),
      .raddr2    (raddr2),
      .rdata1    (rdata1),
      .rdata2    (rdata2),
      .rvalid1   (rvalid1),
      .rvalid2   (rvalid2),
      .wb_err    (wb_err)
   );

   typedef struct {
      logic          rst, v, wen;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdata;
      logic          iv;
      logic [AW-1:0] ird, ra1, ra2;
      logic [DW-1:0] e_rd1;
      logic          e_rv1;
      logic [DW-1:0] e_rd2;
      logic          e_rv2, e_ready, e_err;
   } vec_t;

   vec_t vecs [17];

   int unsigned passed = 0;
   int unsigned total  = 0;

   // Reference model state
   logic [DW-1:0] m_mem  [NUM_REGS];
   logic          m_pend [NUM_REGS];
   logic          m_err, m_ready;

   function automatic vec_t mk(input logic r, v, wen, input int unsigned waddr,
                               input logic [DW-1:0] wdata, input logic iv,
                               input int unsigned ird, ra1, ra2,
                               input logic [DW-1:0] e_rd1, input logic e_rv1,
                               input logic [DW-1:0] e_rd2, input logic e_rv2,
                               input logic e_ready, e_err);
      vec_t t;
      t.rst = r; t.v = v; t.wen = wen; t.waddr = AW'(waddr); t.wdata = wdata;
      t.iv = iv; t.ird = AW'(ird); t.ra1 = AW'(ra1); t.ra2 = AW'(ra2);
      t.e_rd1 = e_rd1; t.e_rv1 = e_rv1; t.e_rd2 = e_rd2; t.e_rv2 = e_rv2;
      t.e_ready = e_ready; t.e_err = e_err;
      return t;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h", name, act, exp);
      else
         passed++;
   endtask

   task automatic drive(input logic r, v, wen, input logic [AW-1:0] waddr,
                        input logic [DW-1:0] wdata, input logic iv,
                        input logic [AW-1:0] ird, ra1, ra2);
      rst = r;
      wb_bus.wb_valid = v;
      wb_bus.wb_wen   = wen;
      wb_bus.wb_waddr = waddr;
      wb_bus.wb_wdata = wdata;
      iss_valid = iv;
      iss_rd    = ird;
      raddr1    = ra1;
      raddr2    = ra2;
   endtask

   task automatic check_all(input string tag, input logic [DW-1:0] e_rd1, input logic e_rv1,
                            input logic [DW-1:0] e_rd2, input logic e_rv2,
                            input logic e_ready, e_err);
      chk({tag, " rdata1"},   rdata1,               e_rd1);
      chk({tag, " rvalid1"},  DW'(rvalid1),         DW'(e_rv1));
      chk({tag, " rdata2"},   rdata2,               e_rd2);
      chk({tag, " rvalid2"},  DW'(rvalid2),         DW'(e_rv2));
      chk({tag, " wb_ready"}, DW'(wb_bus.wb_ready), DW'(e_ready));
      chk({tag, " wb_err"},   DW'(wb_err),          DW'(e_err));
   endtask

   // Read rule: x0 is zero; an accepted write to the same index is seen at once;
   // otherwise stored data, current only if no write is outstanding.
   function automatic logic [DW:0] m_read(input logic [AW-1:0] a);
      int unsigned idx = int'(a);
      if (idx == 0)
         return {1'b1, {DW{1'b0}}};
      if (wb_bus.wb_valid && m_ready && wb_bus.wb_wen && (wb_bus.wb_waddr == a))
         return {1'b1, wb_bus.wb_wdata};
      return {!m_pend[idx], m_mem[idx]};
   endfunction

   task automatic m_edge();
      int unsigned wa = int'(wb_bus.wb_waddr);
      int unsigned ir = int'(iss_rd);
      logic hs;
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
         m_err   = 1'b0;
         m_ready = 1'b0;
      end else begin
         hs = wb_bus.wb_valid && m_ready;
         if (hs && wa != 0 && !m_pend[wa] && !(iss_valid && ir == wa))
            m_err = 1'b1;
         if (hs && wb_bus.wb_wen && wa != 0)
            m_mem[wa] = wb_bus.wb_wdata;
         if (hs)
            m_pend[wa] = 1'b0;
         if (iss_valid && ir != 0)
            m_pend[ir] = 1'b1;
         m_ready = 1'b1;
      end
   endtask

   initial begin
      logic [DW:0] e1, e2;
      logic        r, v, wen, iv;
      logic [AW-1:0] wa, ird, ra1, ra2;

      //           rst v wen wa wdata        iv ird ra1 ra2  e_rd1         rv1 e_rd2         rv2 rdy err
      vecs[0]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 5, 0,  32'h0,        1, 32'h0,        1, 0, 0);
      vecs[1]  = mk(1, 0, 0, 0, 32'h0,        1, 3, 5, 0,  32'h0,        1, 32'h0,        1, 1, 0);
      vecs[2]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 3, 0,  32'h0,        0, 32'h0,        1, 1, 0);
      vecs[3]  = mk(1, 1, 1, 3, 32'h1234,     0, 0, 3, 3,  32'h1234,     1, 32'h1234,     1, 1, 0);
      vecs[4]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 3, 0,  32'h1234,     1, 32'h0,        1, 1, 0);
      vecs[5]  = mk(1, 1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  32'h0,        1, 32'h0,        1, 1, 0);
      vecs[6]  = mk(1, 1, 1, 7, 32'hA5,       1, 7, 7, 3,  32'hA5,       1, 32'h1234,     1, 1, 0);
      vecs[7]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 7,  32'hA5,       0, 32'hA5,       0, 1, 0);
      vecs[8]  = mk(1, 1, 1, 9, 32'h99,       0, 0, 9, 7,  32'h99,       1, 32'hA5,       0, 1, 0);
      vecs[9]  = mk(1, 0, 0, 0, 32'h0,        0, 0, 9, 0,  32'h99,       1, 32'h0,        1, 1, 1);
      vecs[10] = mk(1, 0, 0, 0, 32'h0,        1, 4, 4, 9,  32'h0,        1, 32'h99,       1, 1, 1);
      vecs[11] = mk(1, 0, 0, 0, 32'h0,        0, 0, 4, 4,  32'h0,        0, 32'h0,        0, 1, 1);
      vecs[12] = mk(1, 1, 0, 4, 32'hDEAD,     0, 0, 4, 0,  32'h0,        0, 32'h0,        1, 1, 1);
      vecs[13] = mk(1, 0, 0, 0, 32'h0,        0, 0, 4, 7,  32'h0,        1, 32'hA5,       0, 1, 1);
      vecs[14] = mk(0, 0, 0, 0, 32'h0,        0, 0, 3, 9,  32'h1234,     1, 32'h99,       1, 1, 1);
      vecs[15] = mk(1, 0, 0, 0, 32'h0,        0, 0, 3, 9,  32'h0,        1, 32'h0,        1, 0, 0);
      vecs[16] = mk(1, 0, 0, 0, 32'h0,        0, 0, 7, 4,  32'h0,        1, 32'h0,        1, 1, 0);

      drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
               vecs[i].iv, vecs[i].ird, vecs[i].ra1, vecs[i].ra2);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].e_rd1, vecs[i].e_rv1,
                   vecs[i].e_rd2, vecs[i].e_rv2, vecs[i].e_ready, vecs[i].e_err);
         @(posedge clk);
         #1;
      end

      // State after the table: freshly reset, ready already raised.
      for (int i = 0; i < NUM_REGS; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_err   = 1'b0;
      m_ready = 1'b1;

      for (int c = 0; c < 3000; c++) begin
         r   = ($urandom_range(0, 63) != 0);
         v   = m_ready && ($urandom_range(0, 1) == 1);
         wen = ($urandom_range(0, 3) != 0);
         wa  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         iv  = ($urandom_range(0, 2) == 0);
         ird = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
         ra1 = AW'($urandom_range(0, 7));
         ra2 = ($urandom_range(0, 3) == 0) ? ra1 : AW'($urandom_range(0, 31));
         drive(r, v, wen, wa, DW'($urandom), iv, ird, ra1, ra2);
         #1;
         e1 = m_read(raddr1);
         e2 = m_read(raddr2);
         check_all($sformatf("rnd%0d", c), e1[DW-1:0], e1[DW], e2[DW-1:0], e2[DW],
                   m_ready, m_err);
         @(posedge clk);
         m_edge();
         #1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ysyx_24120013_gpr.md
# ysyx_24120013_gpr

General-purpose register file for the NPC core: the receiving end of the execute-stage write-back interface (wen/waddr/wdata) and the source of operand reads for decode. Holds 2^ADDR_WIDTH registers with x0 hardwired to zero, accepts one write per cycle over a valid/ready handshake, and provides two combinational read ports with write-first bypass. A per-register pending scoreboard, set at issue and cleared at write-back, tells decode whether a read operand is current.

## Interface
- ADDR_WIDTH, 5, register index width; register count = 2^ADDR_WIDTH
- DATA_WIDTH, 32, register width
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- wb_valid  in  1  write-back request
- wb_ready  out  1  GPR accepts write-back this cycle
- wb_wen  in  1  write enable qualifier (0 = handshake completes, no write)
- wb_waddr  in  ADDR_WIDTH  destination index
- wb_wdata  in  DATA_WIDTH  write data
- iss_valid  in  1  instruction issued with a destination
- iss_rd  in  ADDR_WIDTH  destination of issued instruction
- raddr1, raddr2  in  ADDR_WIDTH  read indices
- rdata1, rdata2  out  DATA_WIDTH  read data
- rvalid1, rvalid2  out  1  read data is current (no write pending)
- wb_err  out  1  sticky: write-back to a register with no pending issue

## Operation
- Write fire = wb_valid & wb_ready & wb_wen & (wb_waddr != 0); register updated at the edge.
- wb_valid & wb_ready & !wb_wen: handshake completes, no state change except pending clear (below).
- Any write-back to index 0 is discarded; x0 reads 0, rvalid for x0 always 1.
- Scoreboard: pending[iss_rd] set at edge when iss_valid & iss_rd != 0. pending[wb_waddr] cleared at edge on handshake (wb_valid & wb_ready), regardless of wb_wen.
- Same-cycle issue and write-back to same nonzero index: pending ends set (issue wins).
- wb_err set at edge on handshake with wb_waddr != 0 and pending[wb_waddr] == 0 and no same-cycle issue to it; cleared only by reset.
- Read port n: if raddr == 0 -> rdata 0, rvalid 1. Else if write fire with wb_waddr == raddr -> rdata = wb_wdata, rvalid 1 (bypass). Else rdata = stored value, rvalid = !pending[raddr].
- Both read ports may address the same register; results identical.

## Timing
- Reads: zero-cycle combinational from raddr, storage, pending, and write-back inputs.
- Write: visible in storage one cycle after fire; visible same cycle via bypass.
- wb_ready: registered; 0 during and for the reset cycle, 1 from the first cycle after rst returns high, then held 1.
- Reset (rst = 0 at an edge): all registers <- 0, pending <- 0, wb_err <- 0, wb_ready <- 0. Reset mid-operation discards any in-flight write-back or issue in that cycle.
- Reset outputs: rdata* = 0 for all addresses, rvalid* = 1, wb_ready = 0, wb_err = 0.
- wb_valid must be held with stable payload until wb_ready; with wb_ready low no state changes.

## Structure
- Shared package: NUM_REGS = 2^ADDR_WIDTH, REG_ZERO = 0 index constant; reused by IDU and EXU.
- Sub-module ysyx_24120013_scoreboard: pending vector, set/clear priority, wb_err generation; GPR top holds storage array, handshake register, bypass muxes.

## Test plan
- Reset: hold rst=0 two cycles, release -> wb_ready 0 then 1 next cycle; raddr1=5 -> rdata1 0, rvalid1 1, wb_err 0.
- Issue rd=3, next cycle read raddr1=3 -> rvalid1 0; write-back waddr=3 wdata=0x0000_1234 -> same cycle rdata1 0x1234, rvalid1 1; next cycle stored 0x1234, rvalid1 1.
- Write-back waddr=0 wdata=0xFFFF_FFFF -> raddr1=0 reads 0, rvalid1 1, wb_err stays 0.
- Same cycle iss_rd=7 and write-back waddr=7 wdata=0xA5 -> reg7 = 0xA5, rvalid for 7 = 0 next cycle, wb_err 0.
- Write-back waddr=9 with no prior issue -> reg9 written, wb_err 1 next cycle and sticky until reset.
- Issue rd=4, write-back waddr=4 with wb_wen=0 -> reg4 unchanged, pending cleared, rvalid 1.
